// File: rtl/global_defs.sv
// Shared definitions for the trace front end.
// Holds the parsed operation type, the address width and the request-queue
// constants and entry layout that the queue and the DRAM scheduler share.
package global_defs;

  localparam int ADDRESS_WIDTH = 33;

  typedef enum logic [1:0] {
    NOP    = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    IFETCH = 2'd3
  } parsed_op_t;

  localparam int QUEUE_DEPTH = 16;
  localparam int AGE_WIDTH   = 8;

  typedef struct packed {
    parsed_op_t               op;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [AGE_WIDTH-1:0]     age;
  } queue_entry_t;

  // True for strobes that carry real work (NOP strobes are ignored).
  function automatic logic is_real_op(parsed_op_t op);
    return op != NOP;
  endfunction

endpackage

// File: rtl/request_queue.sv
// request_queue: circular FIFO of pending memory requests fed by the
// parser's op strobe, drained by the DRAM command scheduler.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   op_ready_s      one-cycle strobe, opcode/address valid while high
//   opcode, address parsed operation accompanying the strobe
//   full            queue holds DEPTH entries; parser must not strobe
//   count           occupancy 0..DEPTH
//   dq_valid        head entry present
//   dq_opcode/_address/_age  head entry (NOP/0/0 when empty)
//   dq_ready        scheduler takes the head this cycle
//   overflow_err    sticky: a real strobe arrived while full with no pop
//
// Every output is a register or a function of registers only; the strobe
// and dq_ready only steer next-state logic.
module request_queue #(
  parameter int DEPTH     = global_defs::QUEUE_DEPTH,
  parameter int AGE_WIDTH = global_defs::AGE_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 op_ready_s,
  input  global_defs::parsed_op_t              opcode,
  input  logic [global_defs::ADDRESS_WIDTH-1:0] address,
  output logic                                 full,
  output logic [$clog2(DEPTH):0]               count,
  output logic                                 dq_valid,
  output global_defs::parsed_op_t              dq_opcode,
  output logic [global_defs::ADDRESS_WIDTH-1:0] dq_address,
  output logic [AGE_WIDTH-1:0]                 dq_age,
  input  logic                                 dq_ready,
  output logic                                 overflow_err
);
  import global_defs::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

  // Pointer / occupancy state
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  // Entry storage
  parsed_op_t               op_q   [DEPTH];
  parsed_op_t               op_d   [DEPTH];
  logic [ADDRESS_WIDTH-1:0] addr_q [DEPTH];
  logic [ADDRESS_WIDTH-1:0] addr_d [DEPTH];
  logic [AGE_WIDTH-1:0]     age_q  [DEPTH];
  logic [AGE_WIDTH-1:0]     age_d  [DEPTH];

  logic strobe, push, pop, drop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign dq_valid = (count_q != '0);

  assign pop    = dq_valid && dq_ready;
  assign strobe = op_ready_s && is_real_op(opcode);
  // A pop in the same cycle frees the head slot, so a full queue can still
  // accept; wr_ptr equals rd_ptr then and the new entry lands in that slot.
  assign push   = strobe && (!full || pop);
  assign drop   = strobe && full && !pop;

  // ---------------------------------------------------------------------
  // Pointers, count, overflow flag
  // ---------------------------------------------------------------------
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q | drop;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------
  // Entry array with saturating ages
  // ---------------------------------------------------------------------
  // Ages of free slots also tick; they are never observed, and a slot is
  // always cleared to age 0 when it is (re)filled.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      op_d[i]   = op_q[i];
      addr_d[i] = addr_q[i];
      age_d[i]  = (age_q[i] == AGE_MAX) ? age_q[i] : age_q[i] + 1'b1;
    end
    if (push) begin
      op_d[wr_ptr_q]   = opcode;
      addr_d[wr_ptr_q] = address;
      age_d[wr_ptr_q]  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= NOP;
        addr_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      op_q   <= op_d;
      addr_q <= addr_d;
      age_q  <= age_d;
    end
  end

  // ---------------------------------------------------------------------
  // Head presentation, forced to NOP/0/0 when empty
  // ---------------------------------------------------------------------
  always_comb begin
    dq_opcode  = NOP;
    dq_address = '0;
    dq_age     = '0;
    if (dq_valid) begin
      dq_opcode  = op_q[rd_ptr_q];
      dq_address = addr_q[rd_ptr_q];
      dq_age     = age_q[rd_ptr_q];
    end
  end

  assign count        = count_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_request_queue.sv
// Self-checking bench for request_queue: directed scenarios plus a random
// phase, all compared each cycle against a queue-based reference model.
module tb_request_queue;
  import global_defs::*;

  localparam int DEPTH = 16;
  localparam int AW    = 8;
  localparam int AMAX  = (1 << AW) - 1;

  logic                     clk = 1'b0;
  logic                     rst, op_ready_s, dq_ready;
  parsed_op_t               opcode;
  logic [ADDRESS_WIDTH-1:0] address;
  logic                     full, dq_valid, overflow_err;
  logic [$clog2(DEPTH):0]   count;
  parsed_op_t               dq_opcode;
  logic [ADDRESS_WIDTH-1:0] dq_address;
  logic [AW-1:0]            dq_age;

  request_queue #(.DEPTH(DEPTH), .AGE_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .op_ready_s(op_ready_s), .opcode(opcode),
    .address(address), .full(full), .count(count), .dq_valid(dq_valid),
    .dq_opcode(dq_opcode), .dq_address(dq_address), .dq_age(dq_age),
    .dq_ready(dq_ready), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of {op, addr, cycle it was pushed}.
  typedef struct {
    parsed_op_t               op;
    logic [ADDRESS_WIDTH-1:0] addr;
    int                       t;
  } ent_t;

  ent_t mq[$];
  bit   m_ovf;
  int   cyc;
  int   errs;
  int   checks;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    int a;
    parsed_op_t eop;
    logic [ADDRESS_WIDTH-1:0] ead;
    a = 0; eop = NOP; ead = '0;
    if (mq.size() != 0) begin
      a   = cyc - mq[0].t;
      if (a > AMAX) a = AMAX;
      eop = mq[0].op;
      ead = mq[0].addr;
    end
    chk("count",    64'(count),        64'(mq.size()));
    chk("full",     64'(full),         64'(mq.size() == DEPTH));
    chk("dq_valid", 64'(dq_valid),     64'(mq.size() != 0));
    chk("dq_opcode",64'(dq_opcode),    64'(eop));
    chk("dq_addr",  64'(dq_address),   64'(ead));
    chk("dq_age",   64'(dq_age),       64'(a));
    chk("overflow", 64'(overflow_err), 64'(m_ovf));
  endtask

  // One clock: drive inputs, advance the model by the same edge, compare.
  task automatic step(bit r, bit s, parsed_op_t o, logic [ADDRESS_WIDTH-1:0] a, bit rdy);
    bit fl, pop, push;
    ent_t e;
    rst = r; op_ready_s = s; opcode = o; address = a; dq_ready = rdy;
    fl   = (mq.size() == DEPTH);
    pop  = (mq.size() != 0) && rdy;
    push = s && (o != NOP) && (!fl || pop);
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.op = o; e.addr = a; e.t = cyc;
        mq.push_back(e);
      end
      if (s && o != NOP && fl && !pop) m_ovf = 1'b1;
    end
    compare_all();
  endtask

  function automatic parsed_op_t rnd_real_op();
    return parsed_op_t'(2'($urandom_range(1, 3)));
  endfunction

  function automatic logic [ADDRESS_WIDTH-1:0] rnd_addr();
    return {1'($urandom_range(0, 1)), 32'($urandom())};
  endfunction

  initial begin
    errs = 0; checks = 0; cyc = 0; m_ovf = 1'b0;
    rst = 1'b1; op_ready_s = 1'b0; opcode = NOP; address = '0; dq_ready = 1'b0;

    // Reset state
    step(1, 0, NOP, '0, 0);
    step(1, 0, NOP, '0, 0);

    // Three strobes, then drain in order
    step(0, 1, READ,   33'h1_0000_0040, 0);
    step(0, 1, WRITE,  33'h0_0000_1000, 0);
    step(0, 1, IFETCH, 33'h0_0000_0080, 0);
    chk("three_count", 64'(count), 64'd3);
    chk("three_head_op", 64'(dq_opcode), 64'(READ));
    chk("three_head_addr", 64'(dq_address), 64'h1_0000_0040);
    for (int i = 0; i < 3; i++) step(0, 0, NOP, '0, 1);
    chk("drained_valid", 64'(dq_valid), 64'd0);

    // Fill to 16, then overflow
    for (int i = 0; i < DEPTH; i++) step(0, 1, rnd_real_op(), rnd_addr(), 0);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_count", 64'(count), 64'd16);
    step(0, 1, WRITE, 33'h0_1234_5678, 0);
    chk("ovf_set", 64'(overflow_err), 64'd1);
    chk("ovf_count", 64'(count), 64'd16);
    for (int i = 0; i < 5; i++) step(0, 0, NOP, '0, i > 1);
    chk("ovf_sticky", 64'(overflow_err), 64'd1);

    // Full queue with simultaneous push and pop, then drain across the wrap
    step(1, 0, NOP, '0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, rnd_real_op(), rnd_addr(), 0);
    step(0, 1, IFETCH, 33'h0_DEAD_BEE0, 1);
    chk("pp_count", 64'(count), 64'd16);
    chk("pp_ovf", 64'(overflow_err), 64'd0);
    for (int i = 0; i < DEPTH - 1; i++) step(0, 0, NOP, '0, 1);
    chk("pp_last_addr", 64'(dq_address), 64'h0_DEAD_BEE0);
    chk("pp_last_op", 64'(dq_opcode), 64'(IFETCH));
    step(0, 0, NOP, '0, 1);
    chk("pp_empty", 64'(dq_valid), 64'd0);

    // Age saturation with a NOP strobe in the middle
    step(1, 0, NOP, '0, 0);
    step(0, 1, WRITE, 33'h0_0000_0ABC, 0);
    chk("age_start", 64'(dq_age), 64'd0);
    for (int i = 0; i < 300; i++) step(0, (i == 50), NOP, 33'h0_0000_0555, 0);
    chk("age_sat", 64'(dq_age), 64'd255);
    chk("age_count", 64'(count), 64'd1);

    // Reset with a strobe and a pop in the same cycle
    step(1, 0, NOP, '0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, rnd_real_op(), rnd_addr(), 0);
    step(1, 1, READ, 33'h1_FFFF_FFFF, 1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(dq_valid), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_op", 64'(dq_opcode), 64'(NOP));

    // Random traffic: producer-heavy, then consumer-heavy
    for (int i = 0; i < 600; i++) begin
      bit s, rdy;
      parsed_op_t o;
      s   = ($urandom_range(0, 3) != 0);
      o   = parsed_op_t'(2'($urandom_range(0, 3)));
      rdy = (i < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      step((i == 450), s, o, rnd_addr(), rdy);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
